csd_mult_sequencer: RTL and testbench

Sequences a full-width multiply onto the shared two-term shift-add multiplier (the `two_bit_multiplier` family, parameters `a_N`/`N`).
- Accepts operand `a` and an unsigned multiplier `b` over a valid/ready request channel.
- Recodes `b` into a series of one- or two-power-of-two terms, issuing one term at a time to the multiplier.
- Accumulates the partial products and returns the product over a valid/ready response channel.
- Sits between the compute issue logic and the multiplier; it is the multiplier's sole driver.

---
 rtl/csd_mult_sequencer.sv | 149 ++++++++++++++
 tb/tb_csd_mult_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/csd_mult_sequencer.sv
// Recodes b into CSD-style +/- power-of-two term pairs and drives them one at a time into the shift-add multiplier, accumulating a*b.
// Per term: 1 ISSUE cycle plus multiplier latency; req_rdy is low from acceptance until the product is taken, and rsp_p holds while rsp_rdy is low.
module csd_mult_sequencer #(
  parameter int a_N = 16,
  parameter int N   = 4,
  parameter int B_N = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_vld,
  output logic               req_rdy,
  input  logic [a_N-1:0]     req_a,
  input  logic [B_N-1:0]     req_b,
  output logic               rsp_vld,
  input  logic               rsp_rdy,
  output logic [2*a_N-1:0]   rsp_p,
  output logic [a_N-1:0]     mul_a,
  output logic [N-1:0]       mul_b_i,
  output logic [N-1:0]       mul_b_j,
  output logic               mul_one_term,
  output logic               mul_b_sign,
  output logic               mul_vld,
  input  logic [2*a_N-1:0]   mul_c,
  input  logic               mul_result_vld
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state_q;
  logic [a_N-1:0]     a_q;
  logic [B_N-1:0]     mask_q;
  logic [B_N-1:0]     term_q;
  logic [2*a_N-1:0]   acc_q;
  logic [N-1:0]       bi_q, bj_q;
  logic               one_q, sign_q, mul_vld_q, rsp_vld_q;

  logic [N-1:0]       bi_d, bj_d;
  logic               one_d, sign_d;
  logic [B_N-1:0]     term_d;
  logic [B_N-1:0]     mask_nxt;

  // j: lowest set bit, i: first clear bit above j, k: lowest set bit above i.
  always_comb begin
    int   j, i, k;
    logic found;
    j     = 0;
    i     = B_N;
    k     = 0;
    found = 1'b0;
    for (int n = B_N - 1; n >= 0; n--) if (mask_q[n]) j = n;
    for (int n = B_N - 1; n >= 0; n--) if (n > j && !mask_q[n]) i = n;
    for (int n = B_N - 1; n >= 0; n--) begin
      if (n > i && mask_q[n]) begin
        k     = n;
        found = 1'b1;
      end
    end
    bi_d   = '0;
    bj_d   = '0;
    one_d  = 1'b0;
    sign_d = 1'b0;
    term_d = '0;
    if (i > j + 1) begin
      bi_d   = N'(i);
      bj_d   = N'(j);
      sign_d = 1'b1;
      for (int n = 0; n < B_N; n++) if (n >= j && n < i) term_d[n] = 1'b1;
    end else if (found) begin
      bi_d      = N'(k);
      bj_d      = N'(j);
      term_d[j] = 1'b1;
      term_d[k] = 1'b1;
    end else begin
      bi_d      = N'(j);
      one_d     = 1'b1;
      term_d[j] = 1'b1;
    end
  end

  assign mask_nxt = mask_q & ~term_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      mask_q    <= '0;
      term_q    <= '0;
      acc_q     <= '0;
      bi_q      <= '0;
      bj_q      <= '0;
      one_q     <= 1'b0;
      sign_q    <= 1'b0;
      mul_vld_q <= 1'b0;
      rsp_vld_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_vld) begin
            a_q       <= req_a;
            mask_q    <= req_b;
            acc_q     <= '0;
            rsp_vld_q <= (req_b == '0);
            state_q   <= (req_b == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          bi_q      <= bi_d;
          bj_q      <= bj_d;
          one_q     <= one_d;
          sign_q    <= sign_d;
          term_q    <= term_d;
          mul_vld_q <= 1'b1;
          state_q   <= WAIT;
        end
        WAIT: begin
          if (mul_result_vld) begin
            acc_q     <= acc_q + mul_c;
            mask_q    <= mask_nxt;
            mul_vld_q <= 1'b0;
            if (mask_nxt == '0) begin
              rsp_vld_q <= 1'b1;
              state_q   <= DONE;
            end else begin
              state_q   <= ISSUE;
            end
          end
        end
        DONE: begin
          if (rsp_rdy) begin
            rsp_vld_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_rdy      = (state_q == IDLE) && !rst;
  assign rsp_vld      = rsp_vld_q;
  assign rsp_p        = acc_q;
  assign mul_a        = a_q;
  assign mul_b_i      = bi_q;
  assign mul_b_j      = bj_q;
  assign mul_one_term = one_q;
  assign mul_b_sign   = sign_q;
  assign mul_vld      = mul_vld_q;

endmodule

// File: tb/tb_csd_mult_sequencer.sv
// Directed bench for csd_mult_sequencer with a variable-latency (1-5 cycle) multiplier model.
module tb_csd_mult_sequencer;

  logic        clk, rst;
  logic        req_vld, req_rdy, rsp_vld, rsp_rdy;
  logic [15:0] req_a;
  logic [14:0] req_b;
  logic [31:0] rsp_p;
  logic [15:0] mul_a;
  logic [3:0]  mul_b_i, mul_b_j;
  logic        mul_one_term, mul_b_sign, mul_vld;
  logic [31:0] mul_c;
  logic        mul_result_vld;

  logic        model_pulse, stray_pulse, hold_model;
  logic [31:0] model_c, stray_c;
  logic [63:0] tv;
  int          checks, failures;
  int          term_cnt, vld_rises, cnt;
  logic        active, prev_vld;
  logic [3:0]  lg_bi [0:63];
  logic [3:0]  lg_bj [0:63];
  logic        lg_one [0:63];
  logic        lg_sign [0:63];

  assign mul_result_vld = model_pulse | stray_pulse;
  assign mul_c          = stray_pulse ? stray_c : model_c;

  csd_mult_sequencer #(.a_N(16), .N(4), .B_N(15)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_p(rsp_p),
    .mul_a(mul_a), .mul_b_i(mul_b_i), .mul_b_j(mul_b_j),
    .mul_one_term(mul_one_term), .mul_b_sign(mul_b_sign), .mul_vld(mul_vld),
    .mul_c(mul_c), .mul_result_vld(mul_result_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: logs each term and answers after a random latency.
  initial begin
    model_pulse = 1'b0; model_c = '0; active = 1'b0; cnt = 0;
    term_cnt = 0; vld_rises = 0; prev_vld = 1'b0; tv = '0;
    forever begin
      @(posedge clk); #1;
      model_pulse = 1'b0;
      if (rst) begin
        active   = 1'b0;
        prev_vld = 1'b0;
      end else begin
        if (mul_vld && !prev_vld) vld_rises++;
        prev_vld = mul_vld;
        if (mul_vld && !active && !hold_model) begin
          active = 1'b1;
          cnt    = $urandom_range(1, 5);
          lg_bi[term_cnt % 64]   = mul_b_i;
          lg_bj[term_cnt % 64]   = mul_b_j;
          lg_one[term_cnt % 64]  = mul_one_term;
          lg_sign[term_cnt % 64] = mul_b_sign;
          term_cnt++;
        end
        if (active) begin
          cnt--;
          if (cnt == 0) begin
            if (mul_one_term)    tv = 64'd1 << mul_b_i;
            else if (mul_b_sign) tv = (64'd1 << mul_b_i) - (64'd1 << mul_b_j);
            else                 tv = (64'd1 << mul_b_i) + (64'd1 << mul_b_j);
            model_c     = 32'(64'(mul_a) * tv);
            model_pulse = 1'b1;
            active      = 1'b0;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic txn(input string tag, input logic [15:0] a, input logic [14:0] b,
                     input bit stall, output int lat, output int t0, output int r0);
    logic [63:0] exp;
    int n;
    exp = 64'(a) * 64'(b);
    n = 0;
    while (!req_rdy && n < 20) begin step(); n++; end
    check({tag, " req_rdy_before"}, 64'(req_rdy), 64'd1);
    t0 = term_cnt;
    r0 = vld_rises;
    req_vld = 1'b1; req_a = a; req_b = b;
    step();
    req_vld = 1'b0;
    lat = 1;
    while (!rsp_vld && lat < 300) begin step(); lat++; end
    check({tag, " rsp_vld"}, 64'(rsp_vld), 64'd1);
    check({tag, " rsp_p"}, 64'(rsp_p), exp);
    if (stall) begin
      stray_c = 32'hDEAD_BEEF;
      stray_pulse = 1'b1;
      for (int s = 0; s < 3; s++) begin
        step();
        stray_pulse = 1'b0;
        check({tag, " stall rsp_vld"}, 64'(rsp_vld), 64'd1);
        check({tag, " stall rsp_p"}, 64'(rsp_p), exp);
        check({tag, " stall req_rdy"}, 64'(req_rdy), 64'd0);
      end
    end
    rsp_rdy = 1'b1;
    step();
    rsp_rdy = 1'b0;
    check({tag, " rsp_vld_after"}, 64'(rsp_vld), 64'd0);
    check({tag, " req_rdy_after"}, 64'(req_rdy), 64'd1);
  endtask

  initial begin
    int lat, t0, r0, n;
    logic [15:0] ra;
    logic [14:0] rb;
    checks = 0; failures = 0;
    rst = 1'b1; req_vld = 1'b0; req_a = '0; req_b = '0; rsp_rdy = 1'b0;
    hold_model = 1'b0; stray_pulse = 1'b0; stray_c = '0;
    step(); step();
    check("reset req_rdy", 64'(req_rdy), 64'd0);
    check("reset rsp_vld", 64'(rsp_vld), 64'd0);
    check("reset rsp_p", 64'(rsp_p), 64'd0);
    check("reset mul_vld", 64'(mul_vld), 64'd0);
    check("reset mul_a", 64'(mul_a), 64'd0);
    check("reset mul_b_i", 64'(mul_b_i), 64'd0);
    check("reset mul_b_j", 64'(mul_b_j), 64'd0);
    check("reset one_term", 64'(mul_one_term), 64'd0);
    check("reset b_sign", 64'(mul_b_sign), 64'd0);
    rst = 1'b0;
    step();
    check("post-reset req_rdy", 64'(req_rdy), 64'd1);

    txn("b0", 16'd1234, 15'd0, 1'b0, lat, t0, r0);
    check("b0 latency", 64'(lat), 64'd1);
    check("b0 terms", 64'(term_cnt - t0), 64'd0);
    check("b0 mul_vld rises", 64'(vld_rises - r0), 64'd0);

    txn("5x7", 16'd5, 15'd7, 1'b0, lat, t0, r0);
    check("5x7 terms", 64'(term_cnt - t0), 64'd1);
    check("5x7 b_i", 64'(lg_bi[t0 % 64]), 64'd3);
    check("5x7 b_j", 64'(lg_bj[t0 % 64]), 64'd0);
    check("5x7 sign", 64'(lg_sign[t0 % 64]), 64'd1);
    check("5x7 one", 64'(lg_one[t0 % 64]), 64'd0);

    txn("9x5", 16'd9, 15'd5, 1'b0, lat, t0, r0);
    check("9x5 terms", 64'(term_cnt - t0), 64'd1);
    check("9x5 b_i", 64'(lg_bi[t0 % 64]), 64'd2);
    check("9x5 b_j", 64'(lg_bj[t0 % 64]), 64'd0);
    check("9x5 sign", 64'(lg_sign[t0 % 64]), 64'd0);
    check("9x5 one", 64'(lg_one[t0 % 64]), 64'd0);

    txn("3x11", 16'd3, 15'd11, 1'b0, lat, t0, r0);
    check("3x11 terms", 64'(term_cnt - t0), 64'd2);
    check("3x11 mul_vld rises", 64'(vld_rises - r0), 64'd2);
    check("3x11 t0 b_i", 64'(lg_bi[t0 % 64]), 64'd2);
    check("3x11 t0 b_j", 64'(lg_bj[t0 % 64]), 64'd0);
    check("3x11 t0 sign", 64'(lg_sign[t0 % 64]), 64'd1);
    check("3x11 t0 one", 64'(lg_one[t0 % 64]), 64'd0);
    check("3x11 t1 one", 64'(lg_one[(t0 + 1) % 64]), 64'd1);
    check("3x11 t1 b_i", 64'(lg_bi[(t0 + 1) % 64]), 64'd3);

    txn("max", 16'hFFFF, 15'h7FFF, 1'b0, lat, t0, r0);
    check("max rsp_p const", 64'(rsp_p), 64'h7FFE8001);
    check("max terms", 64'(term_cnt - t0), 64'd1);
    check("max b_i", 64'(lg_bi[t0 % 64]), 64'd15);
    check("max b_j", 64'(lg_bj[t0 % 64]), 64'd0);
    check("max sign", 64'(lg_sign[t0 % 64]), 64'd1);

    // Stall in DONE with a stray multiplier pulse on the first stalled cycle.
    txn("stall", 16'd777, 15'h2A5B, 1'b1, lat, t0, r0);

    // Reset while waiting on the multiplier.
    hold_model = 1'b1;
    n = 0;
    while (!req_rdy && n < 20) begin step(); n++; end
    req_vld = 1'b1; req_a = 16'd5; req_b = 15'd7;
    step();
    req_vld = 1'b0;
    n = 0;
    while (!mul_vld && n < 10) begin step(); n++; end
    check("rstwait reached WAIT", 64'(mul_vld), 64'd1);
    step();
    check("rstwait still waiting", 64'(mul_vld), 64'd1);
    rst = 1'b1;
    step();
    check("rstwait mul_vld", 64'(mul_vld), 64'd0);
    check("rstwait rsp_vld", 64'(rsp_vld), 64'd0);
    check("rstwait req_rdy in reset", 64'(req_rdy), 64'd0);
    rst = 1'b0;
    hold_model = 1'b0;
    step();
    check("rstwait idle req_rdy", 64'(req_rdy), 64'd1);
    check("rstwait idle mul_vld", 64'(mul_vld), 64'd0);
    txn("recover", 16'd7, 15'd3, 1'b0, lat, t0, r0);

    for (int r = 0; r < 12; r++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 15'($urandom_range(0, 32767));
      txn("rand", ra, rb, 1'b0, lat, t0, r0);
      check("rand term bound", 64'(((term_cnt - t0) <= $countones(rb)) ? 1 : 0), 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
